// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32-entry register file, operand/immediate muxing and a
// registered valid/ready slot toward the ALU. Optional macro OPF_WB_BYPASS_EN.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic [3:0]        alu_sel,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] first,
  output logic [DATA_W-1:0] second,
  output logic [3:0]        select
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] first_q,  first_d;
  logic [DATA_W-1:0] second_q, second_d;
  logic [3:0]        select_q, select_d;
  logic [REG_AW-1:0] rs_q,     rs_d;
  logic [REG_AW-1:0] rt_q,     rt_d;
  logic              use_imm_q, use_imm_d;

  logic [DATA_W-1:0] rs_val_s, rt_val_s, imm_ext_s;
  logic              load_s, wb_live_s;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] v,
                                                input logic sx);
    ext_imm = {{(DATA_W-IMM_W){sx & v[IMM_W-1]}}, v};
  endfunction

  assign wb_live_s = wb_en && (wb_addr != {REG_AW{1'b0}});
  assign in_ready  = !valid_q || out_ready;
  assign load_s    = in_valid && in_ready && !flush;
  assign imm_ext_s = ext_imm(imm, sign_ext);

  // Register file next state; entry 0 is never written so it always reads 0
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = (wb_live_s && (wb_addr == REG_AW'(i))) ? wb_data : rf_q[i];
    end
  end

  // Source operand read, optionally forwarding the coincident write-back
  always_comb begin
`ifdef OPF_WB_BYPASS_EN
    if (wb_live_s && (wb_addr == rs_addr)) rs_val_s = wb_data;
    else                                   rs_val_s = rf_q[rs_addr];
    if (wb_live_s && (wb_addr == rt_addr)) rt_val_s = wb_data;
    else                                   rt_val_s = rf_q[rt_addr];
`else
    rs_val_s = rf_q[rs_addr];
    rt_val_s = rf_q[rt_addr];
`endif
  end

  // Slot next state: flush beats load; a held slot tracks writes to its sources
  always_comb begin
    valid_d   = valid_q;
    first_d   = first_q;
    second_d  = second_q;
    select_d  = select_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    use_imm_d = use_imm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d   = 1'b1;
      first_d   = rs_val_s;
      second_d  = use_imm ? imm_ext_s : rt_val_s;
      select_d  = alu_sel;
      rs_d      = rs_addr;
      rt_d      = rt_addr;
      use_imm_d = use_imm;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (wb_live_s && (wb_addr == rs_q)) first_d = wb_data;
      else                                first_d = first_q;
      if (wb_live_s && (wb_addr == rt_q) && !use_imm_q) second_d = wb_data;
      else                                              second_d = second_q;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= {DATA_W{1'b0}};
      valid_q   <= 1'b0;
      first_q   <= {DATA_W{1'b0}};
      second_q  <= {DATA_W{1'b0}};
      select_q  <= 4'd0;
      rs_q      <= {REG_AW{1'b0}};
      rt_q      <= {REG_AW{1'b0}};
      use_imm_q <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      second_q  <= second_d;
      select_q  <= select_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      use_imm_q <= use_imm_d;
    end
  end

  assign out_valid = valid_q;
  assign first     = first_q;
  assign second    = second_q;
  assign select    = select_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// traffic compared against an array/slot reference model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, use_imm, sign_ext, flush, wb_en, out_ready;
  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [15:0] imm;
  logic [3:0]  alu_sel, select;
  logic [31:0] wb_data, first, second;
  logic        in_ready, out_valid;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_reg [32];
  logic        m_valid, m_ui;
  logic [31:0] m_first, m_second;
  logic [3:0]  m_sel;
  logic [4:0]  m_rs, m_rt;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .sign_ext(sign_ext), .alu_sel(alu_sel), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .first(first), .second(second), .select(select)
  );

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef OPF_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_reg[a];
  endfunction

  // Reference model of one clock edge, then advance to just after the edge
  task automatic tick();
    logic ld;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_valid = 1'b0; m_first = 32'd0; m_second = 32'd0; m_sel = 4'd0;
      m_rs = 5'd0; m_rt = 5'd0; m_ui = 1'b0;
    end else begin
      ld = in_valid && (!m_valid || out_ready) && !flush;
      if (flush) m_valid = 1'b0;
      else if (ld) begin
        m_valid  = 1'b1;
        m_first  = m_read(rs_addr);
        m_second = use_imm ? (sign_ext ? 32'($signed(imm)) : {16'd0, imm})
                           : m_read(rt_addr);
        m_sel = alu_sel; m_rs = rs_addr; m_rt = rt_addr; m_ui = use_imm;
      end else if (!m_valid || out_ready) m_valid = 1'b0;
      else if (wb_en && wb_addr != 5'd0) begin
        if (wb_addr == m_rs) m_first = wb_data;
        if (wb_addr == m_rt && !m_ui) m_second = wb_data;
      end
      if (wb_en && wb_addr != 5'd0) m_reg[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; use_imm = 1'b0; sign_ext = 1'b0; flush = 1'b0;
    wb_en = 1'b0; out_ready = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0;
    wb_addr = 5'd0; imm = 16'd0; alu_sel = 4'd0; wb_data = 32'd0;
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                      input logic sx, input logic [15:0] im, input logic [3:0] sel);
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; use_imm = ui; sign_ext = sx;
    imm = im; alu_sel = sel;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (first !== 32'd0) begin failures++; $display("FAIL reset_first got=%h exp=0", first); end
    checks++; if (second !== 32'd0) begin failures++; $display("FAIL reset_second got=%h exp=0", second); end
    checks++; if (select !== 4'd0) begin failures++; $display("FAIL reset_select got=%h exp=0", select); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    idle(); load(5'd3, 5'd4, 1'b0, 1'b0, 16'd0, 4'b0010); tick(); idle(); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (first !== 32'd0 || second !== 32'd0) begin failures++; $display("FAIL basic_ops got=%h/%h exp=0/0", first, second); end
    checks++; if (select !== 4'b0010) begin failures++; $display("FAIL basic_select got=%h exp=2", select); end
    write(5'd0, 32'hFFFF_FFFF); tick(); idle();
    load(5'd0, 5'd0, 1'b0, 1'b0, 16'd0, 4'd0); tick(); idle(); #1;
    checks++; if (first !== 32'd0) begin failures++; $display("FAIL r0_zero got=%h exp=0", first); end
  endtask

  task automatic test_sub();
    idle(); write(5'd5, 32'h10); tick(); write(5'd6, 32'h3); tick(); idle();
    load(5'd5, 5'd6, 1'b0, 1'b0, 16'd0, 4'b0110); tick(); idle(); #1;
    checks++; if (first !== 32'h10 || second !== 32'h3) begin failures++; $display("FAIL sub_ops got=%h/%h exp=10/3", first, second); end
    checks++; if (select !== 4'b0110) begin failures++; $display("FAIL sub_select got=%h exp=6", select); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int n = 0; n < 40; n++) begin
      load(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom));
      wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready n=%0d got=%b exp=1", n, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || first !== m_first || second !== m_second || select !== m_sel) begin
        failures++;
        $display("FAIL b2b_slot n=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", n, out_valid, first, second, select, m_first, m_second, m_sel);
      end
    end
    idle();
  endtask

  task automatic test_imm();
    idle(); load(5'd0, 5'd1, 1'b1, 1'b1, 16'h8000, 4'd2); tick(); #1;
    checks++; if (second !== 32'hFFFF_8000) begin failures++; $display("FAIL imm_sext got=%h exp=ffff8000", second); end
    load(5'd0, 5'd1, 1'b1, 1'b0, 16'h8000, 4'd2); tick(); idle(); #1;
    checks++; if (second !== 32'h0000_8000) begin failures++; $display("FAIL imm_zext got=%h exp=00008000", second); end
  endtask

  task automatic test_stall();
    idle(); write(5'd7, 32'h55); tick(); idle();
    load(5'd7, 5'd7, 1'b0, 1'b0, 16'd0, 4'd1); tick(); idle();
    out_ready = 1'b0; write(5'd7, 32'h1234); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    tick(); wb_en = 1'b0; load(5'd2, 5'd2, 1'b0, 1'b0, 16'd0, 4'd0); #1;
    checks++; if (out_valid !== 1'b1 || first !== 32'h1234 || second !== 32'h1234) begin
      failures++; $display("FAIL stall_refresh got=%b/%h/%h exp=1/1234/1234", out_valid, first, second); end
    tick(); #1;
    checks++; if (in_ready !== 1'b0 || first !== 32'h1234 || select !== 4'd1) begin
      failures++; $display("FAIL stall_hold got=%b/%h/%h exp=0/1234/1", in_ready, first, select); end
    in_valid = 1'b0; out_ready = 1'b1; tick(); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    idle();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_v;
`ifdef OPF_WB_BYPASS_EN
    exp_v = 32'hABCD;
`else
    exp_v = 32'h1111;
`endif
    idle(); write(5'd9, 32'h1111); tick(); idle();
    write(5'd9, 32'hABCD); load(5'd9, 5'd0, 1'b0, 1'b0, 16'd0, 4'd2); tick(); idle(); #1;
    checks++; if (first !== exp_v) begin failures++; $display("FAIL bypass got=%h exp=%h", first, exp_v); end
    load(5'd9, 5'd0, 1'b0, 1'b0, 16'd0, 4'd2); tick(); idle(); #1;
    checks++; if (first !== 32'hABCD) begin failures++; $display("FAIL after_write got=%h exp=abcd", first); end
  endtask

  task automatic test_flush();
    idle(); tick();
    flush = 1'b1; load(5'd5, 5'd6, 1'b0, 1'b0, 16'd0, 4'd2); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick(); idle(); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_load got=%b exp=0", out_valid); end
    load(5'd5, 5'd6, 1'b0, 1'b0, 16'd0, 4'd2); tick(); idle();
    out_ready = 1'b0; flush = 1'b1; write(5'd12, 32'h77); tick(); idle();
    load(5'd12, 5'd0, 1'b0, 1'b0, 16'd0, 4'd0); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held got=%b exp=0", out_valid); end
    tick(); idle(); #1;
    checks++; if (first !== 32'h77) begin failures++; $display("FAIL flush_wb got=%h exp=77", first); end
  endtask

  task automatic test_reset_stall();
    idle(); load(5'd5, 5'd6, 1'b0, 1'b0, 16'd0, 4'd2); tick(); idle();
    out_ready = 1'b0; tick(); rst = 1'b1; tick(); idle(); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 32; i++) begin
      load(5'(i), 5'(31 - i), 1'b0, 1'b0, 16'd0, 4'd0); tick(); #1;
      checks++; if (first !== 32'd0 || second !== 32'd0) begin
        failures++; $display("FAIL rst_regs i=%0d got=%h/%h exp=0/0", i, first, second); end
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 7) == 0);
      rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
      use_imm = 1'($urandom); sign_ext = 1'($urandom); imm = 16'($urandom);
      alu_sel = 4'($urandom); wb_en = 1'($urandom);
      wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready)) begin
        failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, (!m_valid || out_ready)); end
      tick();
      checks++;
      if (out_valid !== m_valid ||
          (m_valid && (first !== m_first || second !== m_second || select !== m_sel))) begin
        failures++;
        $display("FAIL rand_slot n=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", n, out_valid, first, second, select, m_valid, m_first, m_second, m_sel);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_sub();
    test_back_to_back();
    test_imm();
    test_stall();
    test_bypass();
    test_flush();
    test_reset_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
